// File: rtl/vip_axi4s_arbiter_if.sv
// Signal bundle around the packet arbiter: N packed upstream AXI4-Stream sources
// and the single arbitrated output stream.
interface vip_axi4s_arbiter_if #(
  parameter int NR_OF_MASTERS_P = 4,
  parameter int TDATA_WIDTH_P   = 32,
  parameter int TSTRB_WIDTH_P   = TDATA_WIDTH_P / 8,
  parameter int TKEEP_WIDTH_P   = TDATA_WIDTH_P / 8,
  parameter int TID_WIDTH_P     = 2,
  parameter int TDEST_WIDTH_P   = 2,
  parameter int TUSER_WIDTH_P   = 1
);
  localparam int N = NR_OF_MASTERS_P;

  logic [N-1:0]               mst_tvalid;
  logic [N-1:0]               mst_tready;
  logic [N*TDATA_WIDTH_P-1:0] mst_tdata;
  logic [N*TSTRB_WIDTH_P-1:0] mst_tstrb;
  logic [N*TKEEP_WIDTH_P-1:0] mst_tkeep;
  logic [N-1:0]               mst_tlast;
  logic [N*TID_WIDTH_P-1:0]   mst_tid;
  logic [N*TDEST_WIDTH_P-1:0] mst_tdest;
  logic [N*TUSER_WIDTH_P-1:0] mst_tuser;

  logic                       slv_tvalid;
  logic                       slv_tready;
  logic [TDATA_WIDTH_P-1:0]   slv_tdata;
  logic [TSTRB_WIDTH_P-1:0]   slv_tstrb;
  logic [TKEEP_WIDTH_P-1:0]   slv_tkeep;
  logic                       slv_tlast;
  logic [TID_WIDTH_P-1:0]     slv_tid;
  logic [TDEST_WIDTH_P-1:0]   slv_tdest;
  logic [TUSER_WIDTH_P-1:0]   slv_tuser;

  // Environment view: the upstream sources plus the downstream sink.
  modport master (
    output mst_tvalid, mst_tdata, mst_tstrb, mst_tkeep, mst_tlast, mst_tid, mst_tdest, mst_tuser,
    input  mst_tready,
    input  slv_tvalid, slv_tdata, slv_tstrb, slv_tkeep, slv_tlast, slv_tid, slv_tdest, slv_tuser,
    output slv_tready
  );

  // Arbiter view.
  modport slave (
    input  mst_tvalid, mst_tdata, mst_tstrb, mst_tkeep, mst_tlast, mst_tid, mst_tdest, mst_tuser,
    output mst_tready,
    output slv_tvalid, slv_tdata, slv_tstrb, slv_tkeep, slv_tlast, slv_tid, slv_tdest, slv_tuser,
    input  slv_tready
  );
endinterface

// File: rtl/vip_axi4s_arbiter.sv
// Packet-level round-robin arbiter: one granted master owns the registered output
// stream from its first beat until its tlast beat is accepted.
module vip_axi4s_arbiter #(
  parameter int NR_OF_MASTERS_P = 4,
  parameter int TDATA_WIDTH_P   = 32,
  parameter int TSTRB_WIDTH_P   = TDATA_WIDTH_P / 8,
  parameter int TKEEP_WIDTH_P   = TDATA_WIDTH_P / 8,
  parameter int TID_WIDTH_P     = 2,
  parameter int TDEST_WIDTH_P   = 2,
  parameter int TUSER_WIDTH_P   = 1,
  localparam int GW = (NR_OF_MASTERS_P > 1) ? $clog2(NR_OF_MASTERS_P) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  vip_axi4s_arbiter_if.slave    axis,
  output logic                  arb_busy,
  output logic [GW-1:0]         arb_grant
);
  localparam int N = NR_OF_MASTERS_P;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                   state_reg, state_next;
  logic [GW-1:0]            grant_reg, grant_next;
  logic [GW-1:0]            pick_idx;
  logic                     pick_valid;
  logic                     out_ready;
  logic                     mst_hs;

  logic                     slv_tvalid_reg;
  logic [TDATA_WIDTH_P-1:0] slv_tdata_reg;
  logic [TSTRB_WIDTH_P-1:0] slv_tstrb_reg;
  logic [TKEEP_WIDTH_P-1:0] slv_tkeep_reg;
  logic                     slv_tlast_reg;
  logic [TID_WIDTH_P-1:0]   slv_tid_reg;
  logic [TDEST_WIDTH_P-1:0] slv_tdest_reg;
  logic [TUSER_WIDTH_P-1:0] slv_tuser_reg;

  logic [TDATA_WIDTH_P-1:0] tdata_arr [N];
  logic [TSTRB_WIDTH_P-1:0] tstrb_arr [N];
  logic [TKEEP_WIDTH_P-1:0] tkeep_arr [N];
  logic [TID_WIDTH_P-1:0]   tid_arr   [N];
  logic [TDEST_WIDTH_P-1:0] tdest_arr [N];
  logic [TUSER_WIDTH_P-1:0] tuser_arr [N];

  // The output register can take a beat when empty or when it drains this cycle.
  assign out_ready = !slv_tvalid_reg || axis.slv_tready;
  assign mst_hs    = (state_reg == BUSY) && axis.mst_tvalid[grant_reg] && out_ready;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign tdata_arr[gi] = axis.mst_tdata[gi*TDATA_WIDTH_P +: TDATA_WIDTH_P];
      assign tstrb_arr[gi] = axis.mst_tstrb[gi*TSTRB_WIDTH_P +: TSTRB_WIDTH_P];
      assign tkeep_arr[gi] = axis.mst_tkeep[gi*TKEEP_WIDTH_P +: TKEEP_WIDTH_P];
      assign tid_arr[gi]   = axis.mst_tid[gi*TID_WIDTH_P +: TID_WIDTH_P];
      assign tdest_arr[gi] = axis.mst_tdest[gi*TDEST_WIDTH_P +: TDEST_WIDTH_P];
      assign tuser_arr[gi] = axis.mst_tuser[gi*TUSER_WIDTH_P +: TUSER_WIDTH_P];
      assign axis.mst_tready[gi] = (state_reg == BUSY) && (grant_reg == GW'(gi)) && out_ready;
    end
  endgenerate

  // Scan from the farthest offset down so the nearest requester after grant_reg wins.
  always_comb begin
    logic [GW-1:0] idx;
    pick_valid = 1'b0;
    pick_idx   = grant_reg;
    idx        = grant_reg;
    for (int k = N; k >= 1; k--) begin
      idx = GW'((int'(grant_reg) + k) % N);
      if (axis.mst_tvalid[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = BUSY;
          grant_next = pick_idx;
        end
      end
      BUSY: begin
        if (mst_hs && axis.mst_tlast[grant_reg]) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= GW'(N - 1);
      slv_tvalid_reg <= 1'b0;
      slv_tdata_reg  <= '0;
      slv_tstrb_reg  <= '0;
      slv_tkeep_reg  <= '0;
      slv_tlast_reg  <= 1'b0;
      slv_tid_reg    <= '0;
      slv_tdest_reg  <= '0;
      slv_tuser_reg  <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      if (mst_hs) begin
        slv_tvalid_reg <= 1'b1;
        slv_tdata_reg  <= tdata_arr[grant_reg];
        slv_tstrb_reg  <= tstrb_arr[grant_reg];
        slv_tkeep_reg  <= tkeep_arr[grant_reg];
        slv_tlast_reg  <= axis.mst_tlast[grant_reg];
        slv_tid_reg    <= tid_arr[grant_reg];
        slv_tdest_reg  <= tdest_arr[grant_reg];
        slv_tuser_reg  <= tuser_arr[grant_reg];
      end else if (axis.slv_tready) begin
        slv_tvalid_reg <= 1'b0;
      end
    end
  end

  assign axis.slv_tvalid = slv_tvalid_reg;
  assign axis.slv_tdata  = slv_tdata_reg;
  assign axis.slv_tstrb  = slv_tstrb_reg;
  assign axis.slv_tkeep  = slv_tkeep_reg;
  assign axis.slv_tlast  = slv_tlast_reg;
  assign axis.slv_tid    = slv_tid_reg;
  assign axis.slv_tdest  = slv_tdest_reg;
  assign axis.slv_tuser  = slv_tuser_reg;
  assign arb_busy        = (state_reg == BUSY);
  assign arb_grant       = grant_reg;
endmodule

// File: tb/tb_vip_axi4s_arbiter.sv
// Bench for vip_axi4s_arbiter: per-master packet queues feed the DUT, a monitor
// collects output beats, and a round-robin packet-order model predicts them.
module tb_vip_axi4s_arbiter;
  localparam int N = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic [1:0]  id;
    logic [1:0]  dest;
    logic [0:0]  user;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arb_busy;
  logic [1:0] arb_grant;

  vip_axi4s_arbiter_if #(.NR_OF_MASTERS_P(N)) axis ();

  vip_axi4s_arbiter #(.NR_OF_MASTERS_P(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .axis      (axis),
    .arb_busy  (arb_busy),
    .arb_grant (arb_grant)
  );

  always #5 clk = ~clk;

  beat_t        mq   [N][$];
  beat_t        pend [N][$];
  beat_t        exp_q[$];
  beat_t        obs_q[$];
  int           obs_cyc[$];
  bit           drv_en = 1'b0;
  logic [N-1:0] idle_valid_mask = '0;
  int           ready_mode = 0;
  bit           ready_pat[$];
  int           gap_pct = 0;
  int           start_dly[N];
  int           start_base = 0;
  int           cyc_cnt = 0;
  bit           mid_pkt[N];
  bit           seen_ready[N];
  int           hs_cnt[N];
  int           model_last = N - 1;
  int           n_checks = 0;
  int           n_fails = 0;

  // Drives inputs on the falling edge, samples handshakes 1 ns later.
  initial begin
    axis.mst_tvalid = '0; axis.mst_tdata = '0; axis.mst_tstrb = '0; axis.mst_tkeep = '0;
    axis.mst_tlast  = '0; axis.mst_tid   = '0; axis.mst_tdest = '0; axis.mst_tuser = '0;
    axis.slv_tready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        1:       axis.slv_tready = 1'($urandom_range(1));
        2:       axis.slv_tready = (ready_pat.size() > 0) ? ready_pat.pop_front() : 1'b1;
        default: axis.slv_tready = 1'b1;
      endcase
      for (int i = 0; i < N; i++) begin
        beat_t b;
        logic  v;
        b = '0; b.last = 1'b1;
        v = idle_valid_mask[i];
        if (drv_en && mq[i].size() > 0 && (cyc_cnt - start_base) >= start_dly[i]) begin
          b = mq[i][0];
          v = !(mid_pkt[i] && int'($urandom_range(99)) < gap_pct);
        end
        axis.mst_tvalid[i]          = v;
        axis.mst_tdata[i*32 +: 32]  = b.data;
        axis.mst_tstrb[i*4 +: 4]    = b.strb;
        axis.mst_tkeep[i*4 +: 4]    = b.keep;
        axis.mst_tlast[i]           = b.last;
        axis.mst_tid[i*2 +: 2]      = b.id;
        axis.mst_tdest[i*2 +: 2]    = b.dest;
        axis.mst_tuser[i]           = b.user;
      end
      cyc_cnt++;
      #1;
      for (int i = 0; i < N; i++) begin
        if (axis.mst_tready[i]) seen_ready[i] = 1'b1;
        if (axis.mst_tvalid[i] && axis.mst_tready[i] && drv_en && mq[i].size() > 0) begin
          mid_pkt[i] = !mq[i][0].last;
          void'(mq[i].pop_front());
          hs_cnt[i]++;
        end
      end
      if (axis.slv_tvalid && axis.slv_tready) begin
        obs_q.push_back({axis.slv_tdata, axis.slv_tstrb, axis.slv_tkeep, axis.slv_tlast,
                         axis.slv_tid, axis.slv_tdest, axis.slv_tuser});
        obs_cyc.push_back(cyc_cnt);
        $display("beat @%0d: tid=%0d tdata=%h tlast=%0b", cyc_cnt, axis.slv_tid,
                 axis.slv_tdata, axis.slv_tlast);
      end
    end
  end

  task automatic gen_pkt(input int m, input int len, input bit ramp, input logic [31:0] base);
    for (int k = 0; k < len; k++) begin
      beat_t b;
      b.data = ramp ? base + 32'(k) : $urandom();
      b.strb = 4'($urandom());
      b.keep = 4'($urandom());
      b.last = (k == len - 1);
      b.id   = 2'(m);
      b.dest = 2'($urandom());
      b.user = 1'($urandom());
      mq[m].push_back(b);
    end
  endtask

  // Reference: whole packets in round-robin order over masters that still have packets.
  task automatic build_expected();
    int    g;
    bit    found;
    beat_t b;
    for (int i = 0; i < N; i++) pend[i] = mq[i];
    exp_q.delete();
    g = model_last;
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int m;
        m = (g + k) % N;
        if (!found && pend[m].size() > 0) begin
          found = 1'b1;
          g = m;
          while (pend[m].size() > 0) begin
            b = pend[m].pop_front();
            exp_q.push_back(b);
            if (b.last) break;
          end
        end
      end
    end
    model_last = g;
  endtask

  task automatic run_traffic(input int budget, output bit ok);
    bit empty;
    ok = 1'b0;
    start_base = cyc_cnt;
    drv_en = 1'b1;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk); #2;
      empty = 1'b1;
      for (int i = 0; i < N; i++) if (mq[i].size() > 0) empty = 1'b0;
      ok = empty && obs_q.size() >= exp_q.size() && !axis.slv_tvalid && !arb_busy;
    end
    drv_en = 1'b0;
  endtask

  task automatic flush_state();
    for (int i = 0; i < N; i++) begin
      mq[i].delete(); mid_pkt[i] = 1'b0; start_dly[i] = 0;
    end
    obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_reset();
    idle_valid_mask = '1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    n_checks++; if (axis.slv_tvalid !== 1'b0) begin n_fails++; $display("FAIL rst_slv_tvalid: got %b, expected 0", axis.slv_tvalid); end
    n_checks++; if (axis.mst_tready !== 4'b0000) begin n_fails++; $display("FAIL rst_mst_tready: got %b, expected 0000", axis.mst_tready); end
    n_checks++; if (arb_grant !== 2'd3) begin n_fails++; $display("FAIL rst_grant: got %0d, expected 3", arb_grant); end
    n_checks++; if (arb_busy !== 1'b0) begin n_fails++; $display("FAIL rst_busy: got %b, expected 0", arb_busy); end
    n_checks++; if (axis.slv_tdata !== 32'h0) begin n_fails++; $display("FAIL rst_tdata: got %h, expected 0", axis.slv_tdata); end
    rst = 1'b0;
    @(negedge clk); #2;
    n_checks++; if (arb_grant !== 2'd0) begin n_fails++; $display("FAIL rst_first_grant: got %0d, expected 0", arb_grant); end
    n_checks++; if (arb_busy !== 1'b1) begin n_fails++; $display("FAIL rst_first_busy: got %b, expected 1", arb_busy); end
    n_checks++; if (axis.mst_tready !== 4'b0001) begin n_fails++; $display("FAIL rst_first_ready: got %b, expected 0001", axis.mst_tready); end
    idle_valid_mask = '0;
    repeat (4) @(negedge clk);
    flush_state();
    model_last = 0;
  endtask

  task automatic test_fairness();
    bit ok;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    flush_state();
    model_last = N - 1;
    for (int p = 0; p < 3; p++)
      for (int m = 0; m < N; m++) gen_pkt(m, 2, 1'b0, 32'h0);
    build_expected();
    run_traffic(500, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL fair_timeout: got %0d beats, expected %0d", obs_q.size(), exp_q.size()); end
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fails++; $display("FAIL fair_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin n_fails++; $display("FAIL fair_beat%0d: got %h, expected %h", k, obs_q[k], exp_q[k]); end
    end
    // Beats within a packet are back-to-back; one bubble separates packets.
    for (int k = 1; k < obs_cyc.size() && k < exp_q.size(); k++) begin
      n_checks++;
      if (obs_cyc[k] - obs_cyc[k-1] !== (exp_q[k-1].last ? 2 : 1)) begin
        n_fails++;
        $display("FAIL fair_gap%0d: got %0d cycles, expected %0d", k, obs_cyc[k] - obs_cyc[k-1], exp_q[k-1].last ? 2 : 1);
      end
    end
    flush_state();
  endtask

  task automatic test_non_interleave();
    bit ok;
    gen_pkt(1, 8, 1'b0, 32'h0);
    gen_pkt(2, 3, 1'b0, 32'h0);
    exp_q.delete();
    foreach (mq[1][k]) exp_q.push_back(mq[1][k]);
    foreach (mq[2][k]) exp_q.push_back(mq[2][k]);
    model_last = 2;
    start_dly[2] = 2;
    gap_pct = 30;
    run_traffic(500, ok);
    gap_pct = 0;
    n_checks++; if (!ok) begin n_fails++; $display("FAIL nil_timeout: got %0d beats, expected %0d", obs_q.size(), exp_q.size()); end
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fails++; $display("FAIL nil_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin n_fails++; $display("FAIL nil_beat%0d: got %h, expected %h", k, obs_q[k], exp_q[k]); end
    end
    flush_state();
  endtask

  task automatic test_backpressure();
    bit    done;
    bit    prev_stall;
    beat_t prev_beat;
    beat_t cur_beat;
    gen_pkt(0, 5, 1'b1, 32'h10);
    build_expected();
    for (int r = 0; r < 8; r++) begin
      ready_pat.push_back(1'b1); ready_pat.push_back(1'b0);
      ready_pat.push_back(1'b0); ready_pat.push_back(1'b1);
    end
    ready_mode = 2;
    prev_stall = 1'b0;
    prev_beat = '0;
    done = 1'b0;
    start_base = cyc_cnt;
    drv_en = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk); #2;
      cur_beat = {axis.slv_tdata, axis.slv_tstrb, axis.slv_tkeep, axis.slv_tlast,
                  axis.slv_tid, axis.slv_tdest, axis.slv_tuser};
      if (prev_stall) begin
        n_checks++;
        if (axis.slv_tvalid !== 1'b1 || cur_beat !== prev_beat) begin
          n_fails++;
          $display("FAIL bp_hold: got valid=%b %h, expected valid=1 %h", axis.slv_tvalid, cur_beat, prev_beat);
        end
      end
      prev_stall = axis.slv_tvalid && !axis.slv_tready;
      prev_beat = cur_beat;
      done = mq[0].size() == 0 && obs_q.size() >= exp_q.size() && !axis.slv_tvalid;
    end
    drv_en = 1'b0;
    ready_mode = 0;
    ready_pat.delete();
    n_checks++; if (!done) begin n_fails++; $display("FAIL bp_timeout: got %0d beats, expected %0d", obs_q.size(), exp_q.size()); end
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fails++; $display("FAIL bp_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin n_fails++; $display("FAIL bp_beat%0d: got %h, expected %h", k, obs_q[k], exp_q[k]); end
    end
    flush_state();
  endtask

  task automatic test_skip_idle();
    bit ok;
    gen_pkt(1, 2, 1'b0, 32'h0);
    build_expected();
    run_traffic(200, ok);
    n_checks++; if (!ok || obs_q.size() !== exp_q.size()) begin n_fails++; $display("FAIL skip_setup: got %0d beats, expected %0d", obs_q.size(), exp_q.size()); end
    flush_state();
    for (int i = 0; i < N; i++) seen_ready[i] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      gen_pkt(3, $urandom_range(1, 3), 1'b0, 32'h0);
      gen_pkt(1, $urandom_range(1, 3), 1'b0, 32'h0);
    end
    build_expected();
    run_traffic(300, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL skip_timeout: got %0d beats, expected %0d", obs_q.size(), exp_q.size()); end
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fails++; $display("FAIL skip_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin n_fails++; $display("FAIL skip_beat%0d: got %h, expected %h", k, obs_q[k], exp_q[k]); end
    end
    n_checks++; if (seen_ready[0] !== 1'b0) begin n_fails++; $display("FAIL skip_ready0: got %b, expected 0", seen_ready[0]); end
    n_checks++; if (seen_ready[2] !== 1'b0) begin n_fails++; $display("FAIL skip_ready2: got %b, expected 0", seen_ready[2]); end
    flush_state();
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    gen_pkt(2, 4, 1'b1, 32'hA0);
    hs_cnt[2] = 0;
    ok = 1'b0;
    start_base = cyc_cnt;
    drv_en = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk); #2;
      ok = hs_cnt[2] >= 2;
    end
    n_checks++; if (!ok) begin n_fails++; $display("FAIL rmid_timeout: got %0d beats accepted, expected 2", hs_cnt[2]); end
    @(negedge clk); #2;
    rst = 1'b1;
    drv_en = 1'b0;
    @(negedge clk); #2;
    rst = 1'b0;
    n_checks++; if (axis.slv_tvalid !== 1'b0) begin n_fails++; $display("FAIL rmid_tvalid: got %b, expected 0", axis.slv_tvalid); end
    n_checks++; if (arb_grant !== 2'd3) begin n_fails++; $display("FAIL rmid_grant: got %0d, expected 3", arb_grant); end
    n_checks++; if (arb_busy !== 1'b0) begin n_fails++; $display("FAIL rmid_busy: got %b, expected 0", arb_busy); end
    n_checks++; if (axis.mst_tready !== 4'b0000) begin n_fails++; $display("FAIL rmid_ready: got %b, expected 0000", axis.mst_tready); end
    repeat (2) @(negedge clk);
    flush_state();
    model_last = N - 1;
    // Upstream re-sends the dropped packet after reset.
    gen_pkt(2, 4, 1'b1, 32'hA0);
    build_expected();
    run_traffic(200, ok);
    n_checks++; if (!ok || obs_q.size() !== exp_q.size()) begin n_fails++; $display("FAIL rmid_resend_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin n_fails++; $display("FAIL rmid_beat%0d: got %h, expected %h", k, obs_q[k], exp_q[k]); end
    end
    flush_state();
  endtask

  task automatic test_random();
    bit ok;
    for (int r = 0; r < 6; r++) begin
      for (int m = 0; m < N; m++) begin
        int np;
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) gen_pkt(m, $urandom_range(1, 5), 1'b0, 32'h0);
      end
      build_expected();
      ready_mode = 1;
      gap_pct = 25;
      run_traffic(3000, ok);
      ready_mode = 0;
      gap_pct = 0;
      n_checks++; if (!ok) begin n_fails++; $display("FAIL rnd%0d_timeout: got %0d beats, expected %0d", r, obs_q.size(), exp_q.size()); end
      n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fails++; $display("FAIL rnd%0d_count: got %0d, expected %0d", r, obs_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
        n_checks++;
        if (obs_q[k] !== exp_q[k]) begin n_fails++; $display("FAIL rnd%0d_beat%0d: got %h, expected %h", r, k, obs_q[k], exp_q[k]); end
      end
      flush_state();
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      start_dly[i] = 0; mid_pkt[i] = 1'b0; seen_ready[i] = 1'b0; hs_cnt[i] = 0;
    end
    test_reset();
    test_fairness();
    test_non_interleave();
    test_backpressure();
    test_skip_idle();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
